// File: rtl/serial_adder_if.sv
// Request/result bus of the bit-serial adder.
// The master side issues operands and start; the slave side returns status and results.
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (output start, a, b, cin, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop,
// one bit pair per clock (LSB first), with a done pulse when the result registers.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_adder_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nx, sum_r;
   logic [CW-1:0]    cnt;
   logic             carry, cout_r;
   logic             fa_s, fa_c;
   logic             accept, last;
   logic             busy, done;

   // Full-adder cell fed from the operand LSBs and the looped-back carry
   assign fa_s   = a_sh[0] ^ b_sh[0] ^ carry;
   assign fa_c   = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
   assign acc_nx = {fa_s, acc[WIDTH-1:1]};

   assign accept = bus.start && (state == IDLE || state == DONE);
   assign last   = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = RUN;
         RUN:     if (last)      state_nx = DONE;
         DONE:    state_nx = bus.start ? RUN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         RUN:     busy = 1'b1;
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sh   <= '0;
         b_sh   <= '0;
         acc    <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
      end else if (accept) begin
         a_sh  <= bus.a;
         b_sh  <= bus.b;
         carry <= bus.cin;
         cnt   <= '0;
         acc   <= '0;
      end else if (state == RUN) begin
         acc   <= acc_nx;
         carry <= fa_c;
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         cnt   <= cnt + 1'b1;
         // Results only move on the completing step and hold otherwise
         if (last) begin
            sum_r  <= acc_nx;
            cout_r <= fa_c;
         end
      end
   end

   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.sum  = sum_r;
   assign bus.cout = cout_r;
endmodule
